// File: rtl/noc_xbar_pipe_pkg.sv
// Shared constants for the NoC crossbar: port indices, lane FSM encoding
// and the default flit width.
package noc_xbar_pipe_pkg;

  localparam int unsigned N_PORT = 0;
  localparam int unsigned E_PORT = 1;
  localparam int unsigned S_PORT = 2;
  localparam int unsigned W_PORT = 3;
  localparam int unsigned L_PORT = 4;

  localparam int unsigned DATA_WIDTH = 32;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lane_state_e;

endpackage

// File: rtl/xbar_out_lane.sv
// One crossbar output lane: packet lock FSM, source register, P:1 mux and
// output register. XBAR_UTURN_EN allows an input to be routed to its own lane.
module xbar_out_lane
  import noc_xbar_pipe_pkg::*;
#(
  parameter int unsigned P    = 5,
  parameter int unsigned DW   = DATA_WIDTH,
  parameter int unsigned LANE = 0,
  localparam int unsigned IW  = $clog2(P)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [P*DW-1:0] in_data,
  input  logic [P-1:0]    in_valid,
  input  logic [P-1:0]    in_tail,
  input  logic [P-1:0]    sel,
  input  logic            out_ready,
  input  logic            win,
  output logic            req,
  output logic            illegal,
  output logic [IW-1:0]   req_idx,
  output logic [DW-1:0]   out_data,
  output logic            out_valid,
  output logic            out_tail
);

  lane_state_e   state;
  logic [IW-1:0] src;
  logic [IW-1:0] idle_idx;
  logic [P-1:0]  leg_mask;
  logic          grant_legal;
  logic          src_ok;
  logic          can_load;
  logic [DW-1:0] mux_data;
  logic          mux_tail;

  // Constant mask: without U-turns the own-index mux leg folds away.
`ifdef XBAR_UTURN_EN
  assign leg_mask = '1;
`else
  assign leg_mask = ~(P'(1) << LANE);
`endif

  always_comb begin
    idle_idx = '0;
    for (int unsigned i = 0; i < P; i++) begin
      if (sel[i]) idle_idx = IW'(i);
    end
  end

  assign grant_legal = $onehot(sel) && ((sel & ~leg_mask) == '0);
  assign illegal     = (state == IDLE) && (sel != '0) && !grant_legal;
  assign req_idx     = (state == LOCKED) ? src : idle_idx;
  assign src_ok      = (state == LOCKED) || grant_legal;
  assign can_load    = !out_valid || out_ready;
  assign req         = rst && can_load && src_ok && in_valid[req_idx];

  always_comb begin
    mux_data = '0;
    mux_tail = 1'b0;
    for (int unsigned i = 0; i < P; i++) begin
      if (leg_mask[i] && (req_idx == IW'(i))) begin
        mux_data = in_data[i*DW +: DW];
        mux_tail = in_tail[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      src       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_tail  <= 1'b0;
    end else if (req && win) begin
      out_data  <= mux_data;
      out_tail  <= mux_tail;
      out_valid <= 1'b1;
      if (mux_tail) begin
        state <= IDLE;
      end else begin
        state <= LOCKED;
        src   <= req_idx;
      end
    end else if (can_load) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/noc_xbar_pipe.sv
// P x P router crossbar with registered outputs and packet path locking.
// Top level: lane instances, input contention, in_ready OR-tree, sel_err.
module noc_xbar_pipe
  import noc_xbar_pipe_pkg::*;
#(
  parameter int unsigned P  = 5,
  parameter int unsigned DW = DATA_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [P*DW-1:0] in_data,
  input  logic [P-1:0]    in_valid,
  input  logic [P-1:0]    in_tail,
  output logic [P-1:0]    in_ready,
  input  logic [P*P-1:0]  sel_in,
  output logic [P*DW-1:0] out_data,
  output logic [P-1:0]    out_valid,
  output logic [P-1:0]    out_tail,
  input  logic [P-1:0]    out_ready,
  output logic            sel_err
);

  localparam int unsigned IW = $clog2(P);

  logic [P-1:0]    req;
  logic [P-1:0]    win;
  logic [P-1:0]    illegal;
  logic [P*IW-1:0] req_idx;

  for (genvar o = 0; o < P; o++) begin : g_lane
    xbar_out_lane #(
      .P    (P),
      .DW   (DW),
      .LANE (o)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_tail   (in_tail),
      .sel       (sel_in[o*P +: P]),
      .out_ready (out_ready[o]),
      .win       (win[o]),
      .req       (req[o]),
      .illegal   (illegal[o]),
      .req_idx   (req_idx[o*IW +: IW]),
      .out_data  (out_data[o*DW +: DW]),
      .out_valid (out_valid[o]),
      .out_tail  (out_tail[o])
    );
  end

  // A lane loses if any lower-index lane requests the same input.
  always_comb begin
    win = req;
    for (int unsigned o = 1; o < P; o++) begin
      for (int unsigned k = 0; k < o; k++) begin
        if (req[k] && (req_idx[k*IW +: IW] == req_idx[o*IW +: IW])) win[o] = 1'b0;
      end
    end
  end

  always_comb begin
    in_ready = '0;
    for (int unsigned o = 0; o < P; o++) begin
      for (int unsigned i = 0; i < P; i++) begin
        if (win[o] && (req_idx[o*IW +: IW] == IW'(i))) in_ready[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sel_err <= 1'b0;
    end else if (|illegal) begin
      sel_err <= 1'b1;
    end
  end

endmodule

// File: doc/noc_xbar_pipe.md
# noc_xbar_pipe

Parametrised P×P router crossbar with a registered output stage, per-output valid/ready backpressure and packet-level path locking. Sits between the input-port buffers and the output links, taking per-output one-hot grants from the switch arbiters. Each output lane locks to its granted input from head flit through tail flit and holds data under downstream stall.

## Interface
Parameters:
- P, default 5: port count (N, E, S, W, L). Legal range 2..8.
- DW, default 32: flit data width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- in_data  in  P*DW  input flits; input i occupies bits [i*DW +: DW].
- in_valid  in  P  flit present at input i.
- in_tail  in  P  flit at input i is a packet tail (single-flit packet: tail=1).
- in_ready  out  P  flit at input i is consumed this cycle.
- sel_in  in  P*P  grants; bits [o*P +: P] are a one-hot input select for output o; all-zero means no grant.
- out_data  out  P*DW  registered output flits.
- out_valid  out  P  output o holds a flit.
- out_tail  out  P  registered tail flag.
- out_ready  in  P  downstream accepts output o.
- sel_err  out  1  sticky: an illegal grant was seen.

## Operation
- Each output o has a lane FSM with two states, IDLE and LOCKED, and a source register src[o].
- The source in IDLE is the input named by sel_in[o] when that field is exactly one-hot and legal. In LOCKED, the source is src[o], and sel_in[o] is ignored.
- Lane o can load when !out_valid[o] || out_ready[o].
- A transfer on lane o happens when the lane can load, the source is valid, and in_valid[src] is high. It loads out_data, out_tail and out_valid=1, and asserts in_ready[src] combinationally in the same cycle.
- Transitions:
  - IDLE → LOCKED on a transfer of a non-tail flit; src latched.
  - LOCKED → IDLE on a transfer of a tail flit.
  - A tail flit accepted in IDLE leaves the lane IDLE.
- If the lane can load but there is no transfer, out_valid[o] clears. A stalled lane holds out_data, out_tail and out_valid unchanged.
- Contention: if two lanes target the same input in one cycle, the lowest-index output wins. The other lane does not transfer and retries. in_ready[i] is the OR of winning lanes; at most one lane wins.
- Illegal grants: sel_in[o] with more than one bit set, or a U-turn grant (bit o of sel_in[o]) when U-turns are disabled.
  - No transfer happens on that lane.
  - sel_err sets and holds until reset.
  - Lane state is unchanged.
- Widths: index registers are $clog2(P) bits wide. The data path has no arithmetic.

## Timing
- Latency is 1 cycle from input transfer to out_valid.
- Throughput is 1 flit/cycle/lane under continuous out_ready=1.
- in_ready is combinational from in_valid, sel_in, out_ready and lane state; it has no registered path.
- out_* outputs are registered only.
- Reset values: out_data=0, out_valid=0, out_tail=0, sel_err=0, all lanes IDLE, src=0, in_ready=0 during reset.
- Reset mid-packet returns lanes to IDLE and drops the held flit; no partial-packet recovery.
- An input may drop in_valid mid-packet. A LOCKED lane waits and out_valid drops after the drain; the lock holds.

## Configuration
- XBAR_UTURN_EN defined: a grant from input o to output o is legal and is forwarded normally.
- XBAR_UTURN_EN undefined: such a grant is illegal. It causes no transfer and sets sel_err. The U-turn mux leg is not synthesised.

## Structure
- The shared defines header holds:
  - port index constants N_PORT..L_PORT (0..4);
  - lane FSM state encodings IDLE=0, LOCKED=1;
  - default DATA_WIDTH.
- Sub-module xbar_out_lane holds one lane: FSM, src register, P:1 mux and output register. It is instantiated P times via generate.
- The top level holds the contention resolution, the in_ready OR-tree and sel_err.

## Test plan
Configuration for all scenarios: P=5, DW=32.
- Single-flit packet: sel_in[E]=00001 (N), in_valid[N]=1, in_tail[N]=1, data 0xA5A5_0001. Required: in_ready[N]=1 that cycle; next cycle out_valid[E]=1, out_data[E]=0xA5A5_0001; lane E stays IDLE.
- Lock: 3-flit packet L→S with sel_in[S] removed after the head. Required: all three flits delivered in order, one per cycle. A competing grant sel_in[S]=N mid-packet is ignored until the tail is accepted.
- Backpressure: out_ready[W]=0 for 4 cycles while flit 0x1234 is held. Required: out_data[W] stable at 0x1234, in_ready for the source=0; the flit is released on the first out_ready=1 cycle.
- Contention: outputs N and E both grant input L, in_valid[L]=1. Required: in_ready[L]=1, only out_valid[N] set next cycle, lane E retries.
- Illegal grant: sel_in[E]=00011, then a U-turn sel_in[S]=00100 (XBAR_UTURN_EN undefined). Required: no transfer, sel_err=1 and held. With the macro defined, the U-turn flit is delivered.
- Reset: assert rst=0 mid-packet with the lane LOCKED. Required: next cycle all outputs 0 and lanes IDLE; a fresh grant is honoured immediately after release.
